lii_mem_endpoint: RTL and testbench

- Memory-side LII endpoint, directly downstream of the AXI-to-LII request packer. It consumes LII request packets (one header flit plus write-data flits) and executes them against a local word-addressed RAM.
- It returns LII response packets in the form the packer decodes: read-data beats with nonzero tkeep, and a single write-ack flit with tkeep=0 and resp in tdata[1:0].

---
 rtl/lii_mem_endpoint.sv | 158 +++++++++++++++
 tb/tb_lii_mem_endpoint.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lii_mem_endpoint.sv
// lii_mem_endpoint: LII request executor against a local word RAM, returning read beats or a write ack.
// Optional build macro LII_EP_DST_FILTER_EN drops packets whose lii_req_dst differs from cfg_id.
module lii_mem_endpoint #(
  parameter int AXI_AW = 48,
  parameter int AXI_DW = 8,
  parameter int LII_DW = 1024,
  parameter int DEPTH  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LII_DW-1:0]   lii_req_tdata,
  input  logic [LII_DW/8-1:0] lii_req_tkeep,
  input  logic [LII_DW/8-1:0] lii_req_tstrb,
  input  logic                lii_req_tlast,
  input  logic [7:0]          lii_req_src,
  input  logic [7:0]          lii_req_dst,
  input  logic                lii_req_tvalid,
  output logic                lii_req_tready,
  output logic [LII_DW-1:0]   lii_resp_tdata,
  output logic [LII_DW/8-1:0] lii_resp_tkeep,
  output logic [LII_DW/8-1:0] lii_resp_tstrb,
  output logic                lii_resp_tlast,
  output logic [7:0]          lii_resp_src,
  output logic [7:0]          lii_resp_dst,
  output logic                lii_resp_tvalid,
  input  logic                lii_resp_tready,
  input  logic [7:0]          cfg_id,
  output logic [15:0]         err_cnt
);
  localparam int BYTES  = AXI_DW / 8;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BSH    = $clog2(BYTES);
  localparam logic [AXI_AW:0] DEPTH_W = (AXI_AW + 1)'(DEPTH);
  localparam logic [2:0] S_HDR = 3'd0, S_RD = 3'd1, S_WR = 3'd2, S_ACK = 3'd3, S_DRAIN = 3'd4;

  logic [AXI_DW-1:0] ram [DEPTH];
  logic [2:0]        state, pend;
  logic [7:0]        len_q, src_q;
  logic [AXI_AW-1:0] base_q;
  logic [8:0]        beat_q;
  logic              err_q, rd_flag;
  logic [AXI_DW-1:0] resp_w;
  logic              resp_keep;

  logic [1:0]        h_op;
  logic [7:0]        h_len, ld_len;
  logic [AXI_AW-1:0] h_addr, base_hdr, ld_base;
  logic [8:0]        ld_beat;
  logic [AXI_AW:0]   wi;
  logic [ADDR_W-1:0] idx;
  logic oor, drop, hs_req, hs_resp, hdr_hs, is_rd, is_wr, bad, drain_end, wr_hs, wr_last, wr_err;
  logic ld, ack_go, ack_err, rd_done, ack_done, inc;
  logic unused_ok;

  assign h_op     = lii_req_tdata[LII_DW-1 -: 2];
  assign h_len    = lii_req_tdata[LII_DW-3 -: 8];
  assign h_addr   = lii_req_tdata[LII_DW-14 -: AXI_AW];
  assign base_hdr = h_addr >> BSH;
  assign unused_ok = ^{lii_req_tdata, lii_req_tkeep, lii_req_tstrb, lii_req_dst};

`ifdef LII_EP_DST_FILTER_EN
  assign drop = lii_req_dst != cfg_id;
`else
  assign drop = 1'b0;
`endif

  assign lii_req_tready = !rst && state != S_RD && state != S_ACK;
  assign hs_req   = lii_req_tvalid && lii_req_tready;
  assign hs_resp  = lii_resp_tvalid && lii_resp_tready;
  assign hdr_hs   = state == S_HDR && hs_req;
  assign is_rd    = !drop && h_op == 2'b00;
  assign is_wr    = !drop && h_op == 2'b01;
  assign bad      = !drop && h_op[1];
  assign drain_end = state == S_DRAIN && hs_req && lii_req_tlast;
  assign wr_hs    = state == S_WR && hs_req;
  assign rd_done  = state == S_RD && hs_resp && lii_resp_tlast;
  assign ack_done = state == S_ACK && hs_resp;

  // One adder serves both the read-beat prefetch and the current write beat.
  assign ld_base = state == S_HDR ? base_hdr : base_q;
  assign ld_len  = state == S_HDR ? h_len : len_q;
  assign ld_beat = state == S_RD ? beat_q + 9'd1 : state == S_WR ? beat_q : 9'd0;
  assign wi      = {1'b0, ld_base} + (AXI_AW + 1)'(ld_beat);
  assign oor     = wi >= DEPTH_W;
  assign idx     = wi[ADDR_W-1:0];

  assign wr_last = beat_q == {1'b0, len_q};
  assign wr_err  = err_q || oor || (lii_req_tlast ^ wr_last);
  assign ld      = (hdr_hs && is_rd && lii_req_tlast) || (drain_end && pend == S_RD) ||
                   (state == S_RD && hs_resp && !lii_resp_tlast);
  assign ack_go  = (hdr_hs && is_wr && lii_req_tlast) || (drain_end && pend == S_ACK) ||
                   (wr_hs && lii_req_tlast);
  assign ack_err = state == S_WR ? wr_err : (state == S_HDR) || err_q;
  assign inc     = (hdr_hs && bad) || (ld && oor && (state != S_RD || !rd_flag)) ||
                   (ack_done && resp_w[1]);

  assign lii_resp_tdata = {{(LII_DW-AXI_DW){1'b0}}, resp_w};
  assign lii_resp_tkeep = {{(LII_DW/8-BYTES){1'b0}}, {BYTES{resp_keep}}};
  assign lii_resp_tstrb = lii_resp_tkeep;

  always_ff @(posedge clk)
    if (wr_hs && !oor)
      for (int b = 0; b < BYTES; b++)
        if (lii_req_tstrb[b]) ram[idx][b*8 +: 8] <= lii_req_tdata[b*8 +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HDR;
      pend <= S_HDR;
      len_q <= '0;
      src_q <= '0;
      base_q <= '0;
      beat_q <= '0;
      err_q <= 1'b0;
      rd_flag <= 1'b0;
      resp_w <= '0;
      resp_keep <= 1'b0;
      lii_resp_tvalid <= 1'b0;
      lii_resp_tlast <= 1'b0;
      lii_resp_src <= '0;
      lii_resp_dst <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        S_HDR: if (hdr_hs) begin
          src_q <= lii_req_src;
          len_q <= h_len;
          base_q <= base_hdr;
          err_q <= 1'b0;
          pend <= is_rd ? S_RD : S_HDR;
          state <= (drop || bad) ? (lii_req_tlast ? S_HDR : S_DRAIN) :
                   is_rd ? (lii_req_tlast ? S_RD : S_DRAIN) : (lii_req_tlast ? S_ACK : S_WR);
        end
        S_WR: if (wr_hs) begin
          err_q <= wr_err;
          if (lii_req_tlast) state <= S_ACK;
          else if (wr_last) begin
            state <= S_DRAIN;
            pend <= S_ACK;
          end
        end
        S_DRAIN: if (drain_end) state <= pend;
        default: if (rd_done || ack_done) state <= S_HDR;
      endcase
      beat_q <= ld ? ld_beat : wr_hs ? beat_q + 9'd1 : hdr_hs ? 9'd0 : beat_q;
      if (ld) rd_flag <= (state == S_RD && rd_flag) || oor;
      if (ld || ack_go) begin
        lii_resp_tvalid <= 1'b1;
        lii_resp_tlast <= ld ? ld_beat == {1'b0, ld_len} : 1'b1;
        resp_keep <= ld;
        resp_w <= ld ? (oor ? '0 : ram[idx]) : {{(AXI_DW-2){1'b0}}, ack_err, 1'b0};
        lii_resp_src <= cfg_id;
        lii_resp_dst <= state == S_HDR ? lii_req_src : src_q;
      end else if (rd_done || ack_done) lii_resp_tvalid <= 1'b0;
      if (inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_lii_mem_endpoint.sv
// tb_lii_mem_endpoint: directed table vectors plus hand-written burst, stall, error and reset sequences.
module tb_lii_mem_endpoint;
  logic          clk = 1'b0, rst = 1'b1;
  logic [1023:0] req_tdata = '0, resp_tdata;
  logic [127:0]  req_tkeep = '0, req_tstrb = '0, resp_tkeep, resp_tstrb;
  logic          req_tlast = 1'b0, req_tvalid = 1'b0, req_tready;
  logic [7:0]    req_src = 8'h17, req_dst = 8'h42, cfg_id = 8'h42, resp_src, resp_dst;
  logic          resp_tlast, resp_tvalid, resp_tready = 1'b0;
  logic [15:0]   err_cnt;
  int n = 0, fails = 0, w = 0, exp_err = 0;

  lii_mem_endpoint dut (
    .clk(clk), .rst(rst),
    .lii_req_tdata(req_tdata), .lii_req_tkeep(req_tkeep), .lii_req_tstrb(req_tstrb),
    .lii_req_tlast(req_tlast), .lii_req_src(req_src), .lii_req_dst(req_dst),
    .lii_req_tvalid(req_tvalid), .lii_req_tready(req_tready),
    .lii_resp_tdata(resp_tdata), .lii_resp_tkeep(resp_tkeep), .lii_resp_tstrb(resp_tstrb),
    .lii_resp_tlast(resp_tlast), .lii_resp_src(resp_src), .lii_resp_dst(resp_dst),
    .lii_resp_tvalid(resp_tvalid), .lii_resp_tready(resp_tready),
    .cfg_id(cfg_id), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] addr;
    logic [7:0]  d;
    logic        s;
    logic [1:0]  ack;
    logic [7:0]  rd;
    int          derr;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1023:0] hdr(input logic [1:0] op, input logic [7:0] len, input logic [47:0] a);
    logic [1023:0] h;
    h = '0;
    h[1023:1022] = op;
    h[1021:1014] = len;
    h[1010:963] = a;
    return h;
  endfunction

  function automatic logic [1023:0] dat(input logic [7:0] b);
    return {1016'b0, b};
  endfunction

  task automatic send(input logic [1023:0] d, input logic s, input logic l);
    int c;
    req_tdata = d;
    req_tstrb = {127'b0, s};
    req_tkeep = {127'b0, s};
    req_tlast = l;
    req_tvalid = 1'b1;
    c = 0;
    #1;
    while (!req_tready && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!req_tready) chk("send timeout", 64'(req_tready), 64'd1);
    @(negedge clk);
    req_tvalid = 1'b0;
    req_tlast = 1'b0;
  endtask

  task automatic recv(input string nm, input logic [7:0] d, input logic l, input logic k, output int wt);
    resp_tready = 1'b1;
    wt = 0;
    #1;
    while (!resp_tvalid && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    if (!resp_tvalid) chk({nm, " timeout"}, 64'(resp_tvalid), 64'd1);
    else begin
      chk({nm, " data"}, resp_tdata[63:0], {56'b0, d});
      chk({nm, " last"}, 64'(resp_tlast), 64'(l));
      chk({nm, " keep"}, resp_tkeep[63:0], {63'b0, k});
      chk({nm, " strb"}, resp_tstrb[63:0], {63'b0, k});
      chk({nm, " dst"}, 64'(resp_dst), 64'h17);
      chk({nm, " src"}, 64'(resp_src), 64'h42);
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{48'h20,   8'h5A, 1'b1, 2'b00, 8'h5A, 0};
    tbl[1] = '{48'h20,   8'h33, 1'b0, 2'b00, 8'h5A, 0};
    tbl[2] = '{48'h21,   8'hC3, 1'b1, 2'b00, 8'hC3, 0};
    tbl[3] = '{48'hFFE,  8'h77, 1'b1, 2'b00, 8'h77, 0};
    tbl[4] = '{48'h1000, 8'h99, 1'b1, 2'b10, 8'h00, 2};
    tbl[5] = '{48'h20,   8'h01, 1'b1, 2'b00, 8'h01, 0};

    repeat (3) @(negedge clk);
    chk("rst tready", 64'(req_tready), 64'd0);
    chk("rst tvalid", 64'(resp_tvalid), 64'd0);
    chk("rst err_cnt", 64'(err_cnt), 64'd0);
    chk("rst tdata", resp_tdata[63:0], 64'd0);
    rst = 1'b0;
    #1 chk("post-rst tready", 64'(req_tready), 64'd1);
    @(negedge clk);

    send(hdr(2'b01, 8'd3, 48'h10), 1'b0, 1'b0);
    send(dat(8'hA1), 1'b1, 1'b0);
    send(dat(8'hA2), 1'b1, 1'b0);
    send(dat(8'hA3), 1'b1, 1'b0);
    send(dat(8'hA4), 1'b1, 1'b1);
    recv("wr4 ack", 8'h00, 1'b1, 1'b0, w);

    send(hdr(2'b00, 8'd3, 48'h10), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      recv($sformatf("rd4 beat%0d", i), 8'hA1 + 8'(i), i == 3, 1'b1, w);
      chk($sformatf("rd4 gap%0d", i), 64'(w), 64'd0);
    end
    chk("rd4 done", 64'(resp_tvalid), 64'd0);

    begin
      logic [7:0] expd[2];
      logic [7:0] prev_d;
      logic prev_stall;
      int beats;
      expd[0] = 8'hA1;
      expd[1] = 8'hA2;
      beats = 0;
      prev_stall = 1'b0;
      prev_d = '0;
      send(hdr(2'b00, 8'd1, 48'h10), 1'b0, 1'b1);
      for (int c = 0; c < 12 && beats < 2; c++) begin
        resp_tready = c[0];
        #1;
        chk("stall req_tready", 64'(req_tready), 64'd0);
        if (prev_stall) chk("stall hold", 64'(resp_tdata[7:0]), 64'(prev_d));
        if (resp_tvalid && resp_tready) begin
          chk("stall data", 64'(resp_tdata[7:0]), 64'(expd[beats]));
          chk("stall last", 64'(resp_tlast), 64'(beats == 1));
          beats++;
        end
        prev_stall = resp_tvalid && !resp_tready;
        prev_d = resp_tdata[7:0];
        @(negedge clk);
      end
      chk("stall beats", 64'(beats), 64'd2);
      chk("stall done", 64'(resp_tvalid), 64'd0);
      resp_tready = 1'b1;
    end

    send(hdr(2'b01, 8'd1, 48'hFFF), 1'b0, 1'b0);
    send(dat(8'h55), 1'b1, 1'b0);
    send(dat(8'h66), 1'b1, 1'b1);
    recv("edge ack", 8'h02, 1'b1, 1'b0, w);
    chk("edge err_cnt", 64'(err_cnt), 64'd1);
    send(hdr(2'b00, 8'd0, 48'hFFF), 1'b0, 1'b1);
    recv("edge rd", 8'h55, 1'b1, 1'b1, w);

    send(hdr(2'b01, 8'd3, 48'h30), 1'b0, 1'b0);
    send(dat(8'h11), 1'b1, 1'b0);
    send(dat(8'h22), 1'b1, 1'b1);
    recv("early ack", 8'h02, 1'b1, 1'b0, w);
    #1 chk("early next tready", 64'(req_tready), 64'd1);
    chk("early err_cnt", 64'(err_cnt), 64'd2);

    send(hdr(2'b10, 8'd0, 48'h0), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("badop no resp", 64'(resp_tvalid), 64'd0);
      @(negedge clk);
    end
    chk("badop err_cnt", 64'(err_cnt), 64'd3);

    send(hdr(2'b00, 8'd1, 48'h30), 1'b0, 1'b0);
    send(dat(8'hEE), 1'b1, 1'b1);
    recv("drain rd0", 8'h11, 1'b0, 1'b1, w);
    recv("drain rd1", 8'h22, 1'b1, 1'b1, w);

    exp_err = 3;
    for (int i = 0; i < 6; i++) begin
      send(hdr(2'b01, 8'd0, tbl[i].addr), 1'b0, 1'b0);
      send(dat(tbl[i].d), tbl[i].s, 1'b1);
      recv($sformatf("v%0d ack", i), {6'b0, tbl[i].ack}, 1'b1, 1'b0, w);
      send(hdr(2'b00, 8'd0, tbl[i].addr), 1'b0, 1'b1);
      recv($sformatf("v%0d rd", i), tbl[i].rd, 1'b1, 1'b1, w);
      exp_err += tbl[i].derr;
      chk($sformatf("v%0d err_cnt", i), 64'(err_cnt), 64'(exp_err));
    end

    send(hdr(2'b00, 8'd7, 48'h10), 1'b0, 1'b1);
    recv("rst rd0", 8'hA1, 1'b0, 1'b1, w);
    recv("rst rd1", 8'hA2, 1'b0, 1'b1, w);
    rst = 1'b1;
    #1;
    chk("midrst tvalid", 64'(resp_tvalid), 64'd0);
    chk("midrst tready", 64'(req_tready), 64'd0);
    chk("midrst err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel tready", 64'(req_tready), 64'd1);
    send(hdr(2'b00, 8'd0, 48'h10), 1'b0, 1'b1);
    recv("after rst rd", 8'hA1, 1'b1, 1'b1, w);
    chk("after rst one beat", 64'(resp_tvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
